regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values 16 (RV32E) or 32; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, number of read ports, range 1-4.
REQ-004 SHALL have parameter MAX_PEND, default 4, maximum outstanding loads, range 1-15.
REQ-005 SHALL have ports: clk in 1, system clock; rstB in 1, reset, synchronous, active-low.
REQ-006 SHALL have port clkEn in 1, state-update enable.
REQ-007 SHALL have ports rd_addr in NRP*AW, packed read addresses (port k at bits [k*AW +: AW]); rd_data out NRP*XLEN, packed read data.
REQ-008 SHALL have ports wr_en in 1, wr_addr in AW, wr_data in XLEN; ALU writeback.
REQ-009 SHALL have ports ld_issue in 1, ld_rd in AW; load issued, destination to mark pending.
REQ-010 SHALL have ports ld_done in 1, ld_done_rd in AW, ld_data in XLEN; load return.
REQ-011 SHALL have ports stall out 1, pend_cnt out 4, err out 1 (sticky).

Function
REQ-012 SHALL read combinationally; register 0 reads as 0 on every port, regardless of any write.
REQ-013 SHALL write wr_data to wr_addr at posedge clk when clkEn=1, wr_en=1, wr_addr!=0.
REQ-014 SHALL write ld_data to ld_done_rd at posedge when clkEn=1, ld_done=1, ld_done_rd!=0.
REQ-015 SHALL, for same-cycle wr_en and ld_done to the same nonzero register, store wr_data; the busy bit still clears.
REQ-016 SHALL bypass write-first: a read port matching an active write this cycle returns that data, with wr_data taking priority over ld_data; bypass is independent of clkEn.
REQ-017 SHALL keep busy[NREGS]: set on ld_issue (clkEn=1, ld_rd!=0, accepted); cleared on ld_done for ld_done_rd.
REQ-018 SHALL, on same-cycle ld_issue and ld_done to the same register, leave busy set.
REQ-019 SHALL assert stall combinationally when any read port addresses a busy register not cleared by ld_done this cycle.
REQ-020 SHALL also assert stall when ld_issue=1 and ld_rd is already busy, or pend_cnt==MAX_PEND without a same-cycle ld_done.
REQ-021 SHALL not accept a stalled ld_issue: busy and pend_cnt remain unchanged.
REQ-022 SHALL update pend_cnt as follows: +1 on accepted ld_issue, -1 on ld_done of a busy register, unchanged when both occur; it never exceeds MAX_PEND and never wraps below 0.
REQ-023 SHALL set err on ld_done to a register that is not busy; the data is still written, pend_cnt is unchanged, and err clears only on reset.
REQ-024 SHALL set and clear no busy bit for register 0; ld_issue to register 0 is accepted without counting.
REQ-025 SHALL, with clkEn=0, update no register, busy bit, counter or err; stall and rd_data still evaluate combinationally.

Reset
REQ-026 SHALL, at posedge with rstB=0, clear all registers to 0, busy to 0, pend_cnt to 0 and err to 0, overriding clkEn and any same-cycle write or issue.
REQ-027 SHALL, with a load outstanding at reset, drop it; a later ld_done for it sets err.

Verification
REQ-028 Write/read: wr x5=0xDEADBEEF, next cycle read port0=5 -> 0xDEADBEEF; same-cycle read -> bypassed 0xDEADBEEF; wr x0=0x1234 -> reads 0.
REQ-029 Load stall: ld_issue x7, then read x7 -> stall=1 and pend_cnt=1; ld_done x7=0x55 -> same cycle rd_data=0x55, stall=0; next cycle pend_cnt=0.
REQ-030 Collision: same cycle wr x3=0xA, ld_done x3=0xB (x3 busy) -> x3=0xA, busy[3]=0, pend_cnt decrements.
REQ-031 Limit: MAX_PEND=4, issue x1-x4 -> pend_cnt=4; ld_issue x5 -> stall=1 and not accepted; same with ld_done x1 -> accepted, pend_cnt stays 4.
REQ-032 Error/reset: ld_done x9 while not busy -> err=1, x9 written; rstB=0 one cycle -> all reads 0, err=0, pend_cnt=0.
REQ-033 clkEn=0: wr x6=0x77 and ld_issue x8 -> x6 unchanged, busy[8]=0; rd_data for x6 still shows bypassed 0x77 that cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : register file with combinational bypassed reads and a
//                      pending-load scoreboard that drives pipeline stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRP      = 2,
   parameter int MAX_PEND = 4
) (
   input  logic                               clk,
   input  logic                               rstB,
   input  logic                               clkEn,
   input  logic [NRP*$clog2(NREGS)-1:0]       rd_addr,
   output logic [NRP*XLEN-1:0]                rd_data,
   input  logic                               wr_en,
   input  logic [$clog2(NREGS)-1:0]           wr_addr,
   input  logic [XLEN-1:0]                    wr_data,
   input  logic                               ld_issue,
   input  logic [$clog2(NREGS)-1:0]           ld_rd,
   input  logic                               ld_done,
   input  logic [$clog2(NREGS)-1:0]           ld_done_rd,
   input  logic [XLEN-1:0]                    ld_data,
   output logic                               stall,
   output logic [3:0]                         pend_cnt,
   output logic                               err
);

   localparam int       AW    = $clog2(NREGS);
   localparam logic [3:0] C_MAX = 4'(MAX_PEND);

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [3:0]       r_pend;
   logic             r_err;

   logic             w_wr_nz;
   logic             w_done_nz;
   logic             w_done_dec;
   logic             w_done_err;
   logic [NREGS-1:0] w_clear;
   logic [NREGS-1:0] w_set;
   logic [NREGS-1:0] w_pend_eff;
   logic             w_rd_stall;
   logic             w_iss_stall;
   logic             w_accept;
   logic             w_inc;

   assign w_wr_nz    = wr_en && (wr_addr != '0);
   assign w_done_nz  = ld_done && (ld_done_rd != '0);
   assign w_done_dec = w_done_nz && r_busy[ld_done_rd];
   assign w_done_err = w_done_nz && !r_busy[ld_done_rd];

   always_comb begin
      w_clear = '0;
      if (w_done_nz) begin
         w_clear[ld_done_rd] = 1'b1;
      end
   end

   // A register whose load returns this cycle no longer holds up a reader.
   assign w_pend_eff = r_busy & ~w_clear;

   always_comb begin
      w_rd_stall = 1'b0;
      for (int k = 0; k < NRP; k++) begin
         if (w_pend_eff[rd_addr[k*AW +: AW]]) begin
            w_rd_stall = 1'b1;
         end
      end
   end

   assign w_iss_stall = ld_issue &&
                        (w_pend_eff[ld_rd] || ((r_pend == C_MAX) && !w_done_dec));
   assign stall       = w_rd_stall || w_iss_stall;

   // A stalled cycle issues nothing, whatever the cause of the stall.
   assign w_accept = ld_issue && !stall;
   assign w_inc    = w_accept && (ld_rd != '0);

   always_comb begin
      w_set = '0;
      if (w_inc) begin
         w_set[ld_rd] = 1'b1;
      end
   end

   generate
      for (genvar k = 0; k < NRP; k++) begin : g_rd
         logic [AW-1:0]   w_a;
         logic [XLEN-1:0] w_rdata;

         assign w_a = rd_addr[k*AW +: AW];

         always_comb begin
            if (w_a == '0) begin
               w_rdata = '0;
            end else if (wr_en && (wr_addr == w_a)) begin
               w_rdata = wr_data;
            end else if (ld_done && (ld_done_rd == w_a)) begin
               w_rdata = ld_data;
            end else begin
               w_rdata = r_regs[w_a];
            end
         end

         assign rd_data[k*XLEN +: XLEN] = w_rdata;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rstB) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
         r_pend <= '0;
         r_err  <= 1'b0;
      end else if (clkEn) begin
         if (w_done_nz) begin
            r_regs[ld_done_rd] <= ld_data;
         end
         // ALU writeback is assigned last so it wins a same-register collision.
         if (w_wr_nz) begin
            r_regs[wr_addr] <= wr_data;
         end
         r_busy <= w_pend_eff | w_set;
         r_pend <= r_pend + {3'b000, w_inc} - {3'b000, w_done_dec};
         if (w_done_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign pend_cnt = r_pend;
   assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed scenarios plus randomized traffic against a
//                         behavioural register-file / pending-load model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int NRP      = 2;
   localparam int MAX_PEND = 4;
   localparam int AW       = 5;

   logic                clk = 1'b0;
   logic                rstB;
   logic                clkEn;
   logic [NRP*AW-1:0]   rd_addr;
   logic [NRP*XLEN-1:0] rd_data;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                ld_issue;
   logic [AW-1:0]       ld_rd;
   logic                ld_done;
   logic [AW-1:0]       ld_done_rd;
   logic [XLEN-1:0]     ld_data;
   logic                stall;
   logic [3:0]          pend_cnt;
   logic                err;

   int checks   = 0;
   int failures = 0;

   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];
   bit              m_err;

   regfile_scoreboard #(
      .XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .MAX_PEND(MAX_PEND)
   ) dut (
      .clk(clk), .rstB(rstB), .clkEn(clkEn),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ld_issue(ld_issue), .ld_rd(ld_rd),
      .ld_done(ld_done), .ld_done_rd(ld_done_rd), .ld_data(ld_data),
      .stall(stall), .pend_cnt(pend_cnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Outstanding loads are exactly the busy destinations.
   function automatic int m_pend();
      int n = 0;
      for (int i = 0; i < NREGS; i++) n += m_busy[i] ? 1 : 0;
      return n;
   endfunction

   function automatic bit m_busy_now(input int a);
      return m_busy[a] && !(ld_done && (int'(ld_done_rd) == a));
   endfunction

   function automatic logic [XLEN-1:0] m_read(input int a);
      if (a == 0) return '0;
      if (wr_en && int'(wr_addr) == a) return wr_data;
      if (ld_done && int'(ld_done_rd) == a) return ld_data;
      return m_regs[a];
   endfunction

   function automatic bit m_stall();
      bit s = 1'b0;
      for (int k = 0; k < NRP; k++) if (m_busy_now(int'(rd_addr[k*AW +: AW]))) s = 1'b1;
      if (ld_issue) begin
         if (m_busy_now(int'(ld_rd))) s = 1'b1;
         if (m_pend() == MAX_PEND && !(ld_done && m_busy[ld_done_rd])) s = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [AW-1:0] port_addr(input int k);
      return rd_addr[k*AW +: AW];
   endfunction

   task automatic idle();
      rstB = 1'b1; clkEn = 1'b1; rd_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      ld_issue = 1'b0; ld_rd = '0; ld_done = 1'b0; ld_done_rd = '0; ld_data = '0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   // Check combinational and registered outputs, then advance one clock.
   task automatic step();
      bit s_exp;
      bit acc;
      #1;
      s_exp = m_stall();
      for (int k = 0; k < NRP; k++)
         check($sformatf("rd%0d_x%0d", k, port_addr(k)), 64'(rd_data[k*XLEN +: XLEN]),
               64'(m_read(int'(port_addr(k)))));
      check("stall", 64'(stall), 64'(s_exp));
      check("pend_cnt", 64'(pend_cnt), 64'(m_pend()));
      check("err", 64'(err), 64'(m_err));
      @(posedge clk);
      if (!rstB) begin
         for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
         m_err = 1'b0;
      end else if (clkEn) begin
         acc = ld_issue && !s_exp;
         if (ld_done && ld_done_rd != 0) begin
            if (!m_busy[ld_done_rd]) m_err = 1'b1;
            m_regs[ld_done_rd] = ld_data;
            m_busy[ld_done_rd] = 1'b0;
         end
         if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
         if (acc && ld_rd != 0) m_busy[ld_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      int q[$];
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_err = 1'b0;
      idle();
      rstB = 1'b0;
      @(negedge clk);
      step();
      idle();
      #1;
      check("rst_pend", 64'(pend_cnt), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);

      // write / read / bypass / x0
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5, 0);
      #1 check("bypass_x5", 64'(rd_data[XLEN-1:0]), 64'hDEADBEEF);
      step();
      idle(); set_rd(5, 0);
      #1 check("read_x5", 64'(rd_data[XLEN-1:0]), 64'hDEADBEEF);
      step();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; set_rd(0, 0);
      step();
      idle(); set_rd(0, 5);
      #1 check("read_x0", 64'(rd_data[XLEN-1:0]), 64'd0);
      step();

      // load stall and same-cycle return
      idle(); ld_issue = 1'b1; ld_rd = 5'd7; step();
      idle(); set_rd(7, 0);
      #1 check("ld_stall", 64'(stall), 64'd1);
      check("ld_pend1", 64'(pend_cnt), 64'd1);
      step();
      ld_done = 1'b1; ld_done_rd = 5'd7; ld_data = 32'h55;
      #1 check("ld_byp", 64'(rd_data[XLEN-1:0]), 64'h55);
      check("ld_unstall", 64'(stall), 64'd0);
      step();
      idle();
      #1 check("ld_pend0", 64'(pend_cnt), 64'd0);

      // collision of ALU writeback and load return
      ld_issue = 1'b1; ld_rd = 5'd3; step();
      idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA;
      ld_done = 1'b1; ld_done_rd = 5'd3; ld_data = 32'hB; step();
      idle(); set_rd(3, 0);
      #1 check("coll_x3", 64'(rd_data[XLEN-1:0]), 64'hA);
      check("coll_nostall", 64'(stall), 64'd0);
      check("coll_pend", 64'(pend_cnt), 64'd0);
      step();

      // pending limit
      for (int r = 1; r <= 4; r++) begin idle(); ld_issue = 1'b1; ld_rd = AW'(r); step(); end
      idle(); ld_issue = 1'b1; ld_rd = 5'd5;
      #1 check("lim_pend4", 64'(pend_cnt), 64'd4);
      check("lim_stall", 64'(stall), 64'd1);
      step();
      ld_done = 1'b1; ld_done_rd = 5'd1; ld_data = 32'h11;
      #1 check("lim_accept", 64'(stall), 64'd0);
      step();
      idle(); set_rd(5, 0);
      #1 check("lim_x5busy", 64'(stall), 64'd1);
      check("lim_pend_hold", 64'(pend_cnt), 64'd4);
      step();
      for (int r = 2; r <= 5; r++) begin
         idle(); ld_done = 1'b1; ld_done_rd = AW'(r); ld_data = 32'(r); step();
      end

      // error, reset, dropped outstanding load
      idle(); ld_done = 1'b1; ld_done_rd = 5'd9; ld_data = 32'h99; step();
      idle(); set_rd(9, 0);
      #1 check("err_set", 64'(err), 64'd1);
      check("err_x9", 64'(rd_data[XLEN-1:0]), 64'h99);
      step();
      ld_issue = 1'b1; ld_rd = 5'd10; step();
      idle(); rstB = 1'b0; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h5; step();
      idle(); set_rd(9, 12);
      #1 check("rst_x9", 64'(rd_data[XLEN-1:0]), 64'd0);
      check("rst_x12", 64'(rd_data[2*XLEN-1:XLEN]), 64'd0);
      check("rst_err0", 64'(err), 64'd0);
      check("rst_pend0", 64'(pend_cnt), 64'd0);
      step();
      idle(); ld_done = 1'b1; ld_done_rd = 5'd10; ld_data = 32'h1; step();
      idle();
      #1 check("drop_err", 64'(err), 64'd1);
      rstB = 1'b0; step();

      // clock enable low
      idle(); clkEn = 1'b0; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h77;
      ld_issue = 1'b1; ld_rd = 5'd8; set_rd(6, 8);
      #1 check("ce_byp", 64'(rd_data[XLEN-1:0]), 64'h77);
      step();
      idle(); set_rd(6, 8);
      #1 check("ce_x6", 64'(rd_data[XLEN-1:0]), 64'd0);
      check("ce_busy8", 64'(stall), 64'd0);
      check("ce_pend", 64'(pend_cnt), 64'd0);
      step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         rstB  = ($urandom % 80) != 0;
         clkEn = ($urandom % 8) != 0;
         wr_en = $urandom % 2; wr_addr = AW'($urandom); wr_data = $urandom;
         ld_issue = ($urandom % 3) == 0; ld_rd = AW'($urandom);
         if (ld_rd == 0 && m_pend() == MAX_PEND) ld_rd = 5'd1;
         q.delete();
         for (int i = 1; i < NREGS; i++) if (m_busy[i]) q.push_back(i);
         if (q.size() != 0 && ($urandom % 3) == 0) begin
            ld_done = 1'b1; ld_done_rd = AW'(q[$urandom % q.size()]);
         end else if (($urandom % 40) == 0) begin
            ld_done = 1'b1; ld_done_rd = AW'($urandom_range(1, NREGS - 1));
         end
         ld_data = $urandom;
         for (int k = 0; k < NRP; k++)
            rd_addr[k*AW +: AW] = (q.size() != 0 && ($urandom % 4) == 0) ?
                                  AW'(q[$urandom % q.size()]) : AW'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
